iob_fifo_sync_asym: RTL and testbench

- Single-clock FIFO with independent write and read widths (e.g. 32-bit in, 8-bit out, or the reverse).
- It is the initiator for the banked external memory used by the asymmetric two-port RAM.
- Stores into N external MINDATA_W-wide iob_ram_2p banks and generates all bank addresses and enables from its write and read pointers.
- Used for width conversion between peripherals and cores.

---
 rtl/iob_fifo_sync_asym.sv | 148 ++++++++++++++
 tb/tb_iob_fifo_sync_asym.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_sync_asym.sv
// iob_fifo_sync_asym: single-clock FIFO with independent write and read widths.
// Data lives in N external MINDATA_W-wide two-port RAM banks. This block drives
// every bank address, enable and write lane from its narrow-word pointers.
// Optional sticky overflow/underflow flags: define IOB_FIFO_SYNC_ASYM_ERR_EN.
module iob_fifo_sync_asym #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 10,
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int N         = MAXDATA_W / MINDATA_W,
    localparam int LOG2N     = $clog2(N),
    localparam int MINADDR_W = ADDR_W - LOG2N
) (
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
    output logic                      w_err,
    output logic                      r_err,
`endif
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      w_en,
    input  logic [W_DATA_W-1:0]       w_data,
    output logic                      w_full,
    input  logic                      r_en,
    output logic [R_DATA_W-1:0]       r_data,
    output logic                      r_valid,
    output logic                      r_empty,
    output logic [ADDR_W:0]           level,
    output logic [N-1:0]              ext_mem_w_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_w_addr,
    output logic [N*MINDATA_W-1:0]    ext_mem_w_data,
    output logic                      ext_mem_r_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_r_addr,
    input  logic [N*MINDATA_W-1:0]    ext_mem_r_data
);

    localparam int W_INCR = W_DATA_W / MINDATA_W;
    localparam int R_INCR = R_DATA_W / MINDATA_W;

    localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'((2 ** ADDR_W) - W_INCR);
    localparam logic [ADDR_W:0]   W_STEP     = (ADDR_W+1)'(W_INCR);
    localparam logic [ADDR_W:0]   R_STEP     = (ADDR_W+1)'(R_INCR);
    localparam logic [ADDR_W-1:0] W_PTR_STEP = ADDR_W'(W_INCR);
    localparam logic [ADDR_W-1:0] R_PTR_STEP = ADDR_W'(R_INCR);

    logic [ADDR_W-1:0]   r_wPtr;
    logic [ADDR_W-1:0]   r_rPtr;
    logic [ADDR_W:0]     r_level;
    logic                r_rValid;
    logic [ADDR_W-1:0]   r_rBank;
    logic [R_DATA_W-1:0] r_rDataHold;

    logic                w_wAccept;
    logic                w_rAccept;
    int                  w_wBank;
    logic [ADDR_W-1:0]   w_rBank;
    logic [R_DATA_W-1:0] w_rDataLive;

    // Flags come straight from the level register so they reflect the pre-update occupancy.
    assign w_full    = r_level > FULL_LEVEL;
    assign r_empty   = r_level < R_STEP;
    assign w_wAccept = w_en & ~w_full;
    assign w_rAccept = r_en & ~r_empty;
    assign level     = r_level;
    assign r_valid   = r_rValid;

    // Narrow address a lives in bank (a mod N) at row a/N; every bank shares the row.
    assign w_wBank        = int'(r_wPtr) % N;
    assign w_rBank        = r_rPtr % ADDR_W'(N);
    assign ext_mem_w_addr = {N{r_wPtr[ADDR_W-1:LOG2N]}};
    assign ext_mem_r_addr = {N{r_rPtr[ADDR_W-1:LOG2N]}};
    assign ext_mem_r_en   = w_rAccept;

    // Enable the W_INCR consecutive banks starting at the write bank (all of them for a wide write).
    always_comb begin
        ext_mem_w_en = '0;
        for (int k = 0; k < N; k++) begin
            if (w_wAccept && (k >= w_wBank) && (k < w_wBank + W_INCR)) begin
                ext_mem_w_en[k] = 1'b1;
            end
        end
    end

    // A wide write spreads little-endian over the lanes; a narrow write is broadcast and the enable picks the bank.
    generate
        if (W_DATA_W == MAXDATA_W) begin : g_wideWrite
            assign ext_mem_w_data = w_data;
        end else begin : g_narrowWrite
            assign ext_mem_w_data = {N{w_data}};
        end
    endgenerate

    // The registered bank index picks the returning lane; for a wide read it stays at lane 0 and takes every lane.
    assign w_rDataLive = ext_mem_r_data[r_rBank*MINDATA_W +: R_DATA_W];
    assign r_data      = r_rValid ? w_rDataLive : r_rDataHold;

    // Pointers advance by the narrow-word size of each accepted transfer and wrap naturally.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wPtr <= '0;
            r_rPtr <= '0;
        end else begin
            if (w_wAccept) r_wPtr <= r_wPtr + W_PTR_STEP;
            if (w_rAccept) r_rPtr <= r_rPtr + R_PTR_STEP;
        end
    end

    // Occupancy in narrow words, adjusted for whichever sides were accepted this cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_level <= '0;
        end else begin
            case ({w_wAccept, w_rAccept})
                2'b10:   r_level <= r_level + W_STEP;
                2'b01:   r_level <= r_level - R_STEP;
                2'b11:   r_level <= r_level + W_STEP - R_STEP;
                default: r_level <= r_level;
            endcase
        end
    end

    // Read return tracking: valid one cycle after an accepted read, and the last word is kept for when valid drops.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rValid    <= 1'b0;
            r_rBank     <= '0;
            r_rDataHold <= '0;
        end else begin
            r_rValid <= w_rAccept;
            if (w_rAccept) r_rBank <= w_rBank;
            if (r_rValid) r_rDataHold <= w_rDataLive;
        end
    end

`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
    // Sticky flags recording any write attempted while full or read attempted while empty.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_err <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_en & w_full)  w_err <= 1'b1;
            if (r_en & r_empty) r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Testbench for iob_fifo_sync_asym: a 32->8 instance (ADDR_W=10) and an 8->32
// instance (ADDR_W=4), each with a behavioural model of its external RAM banks.
// Expected read data is queued when a read is accepted and compared on return.
module tb_iob_fifo_sync_asym;

   logic clk = 1'b0;
   logic arst_n;
   always #5 clk = ~clk;

   int vecCount = 0;
   int missCount = 0;

   // 32-bit write / 8-bit read instance
   logic        aWEn, aREn, aWFull, aRValid, aREmpty, aMemREn;
   logic [31:0] aWData;
   logic [7:0]  aRData;
   logic [10:0] aLevel;
   logic [3:0]  aMemWEn;
   logic [31:0] aMemWAddr, aMemWData, aMemRAddr, aMemRData;

   // 8-bit write / 32-bit read instance
   logic        bWEn, bREn, bWFull, bRValid, bREmpty, bMemREn;
   logic [7:0]  bWData;
   logic [31:0] bRData;
   logic [4:0]  bLevel;
   logic [3:0]  bMemWEn;
   logic [7:0]  bMemWAddr, bMemRAddr;
   logic [31:0] bMemWData, bMemRData;

`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
   logic aWErr, aRErr, bWErr, bRErr;
`endif

   iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(10)) dutA (
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
      .w_err(aWErr), .r_err(aRErr),
`endif
      .clk(clk), .arst_n(arst_n),
      .w_en(aWEn), .w_data(aWData), .w_full(aWFull),
      .r_en(aREn), .r_data(aRData), .r_valid(aRValid), .r_empty(aREmpty),
      .level(aLevel),
      .ext_mem_w_en(aMemWEn), .ext_mem_w_addr(aMemWAddr), .ext_mem_w_data(aMemWData),
      .ext_mem_r_en(aMemREn), .ext_mem_r_addr(aMemRAddr), .ext_mem_r_data(aMemRData)
   );

   iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dutB (
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
      .w_err(bWErr), .r_err(bRErr),
`endif
      .clk(clk), .arst_n(arst_n),
      .w_en(bWEn), .w_data(bWData), .w_full(bWFull),
      .r_en(bREn), .r_data(bRData), .r_valid(bRValid), .r_empty(bREmpty),
      .level(bLevel),
      .ext_mem_w_en(bMemWEn), .ext_mem_w_addr(bMemWAddr), .ext_mem_w_data(bMemWData),
      .ext_mem_r_en(bMemREn), .ext_mem_r_addr(bMemRAddr), .ext_mem_r_data(bMemRData)
   );

   // Four 8-bit banks of 256 rows with registered read, as seen by instance A
   logic [7:0] memA [0:3][0:255];
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (aMemWEn[k]) memA[k][aMemWAddr[k*8 +: 8]] <= aMemWData[k*8 +: 8];
         if (aMemREn) aMemRData[k*8 +: 8] <= memA[k][aMemRAddr[k*8 +: 8]];
      end
   end

   // Four 8-bit banks of 4 rows with registered read, as seen by instance B
   logic [7:0] memB [0:3][0:3];
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bMemWEn[k]) memB[k][bMemWAddr[k*2 +: 2]] <= bMemWData[k*8 +: 8];
         if (bMemREn) bMemRData[k*8 +: 8] <= memB[k][bMemRAddr[k*2 +: 2]];
      end
   end

   // Reference model state
   logic [7:0]  qA[$];
   logic [7:0]  expQA[$];
   logic [7:0]  qB[$];
   logic [31:0] expQB[$];
   logic        errWA, errRA, errWB, errRB;
   logic        haveLastA, haveLastB;
   logic [7:0]  lastA;
   logic [31:0] lastB;
   int          bWrCount;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clearModels();
      qA.delete(); expQA.delete(); qB.delete(); expQB.delete();
      errWA = 1'b0; errRA = 1'b0; errWB = 1'b0; errRB = 1'b0;
      haveLastA = 1'b0; haveLastB = 1'b0; bWrCount = 0;
   endtask

   // One cycle on instance A: drive, check bank strobes, clock, check flags and returned data
   task automatic applyStimulusA(input logic wEn, input logic [31:0] wData, input logic rEn);
      logic wAcc, rAcc;
      int   lvl;
      wAcc = wEn && !(qA.size() > 1020);
      rAcc = rEn && (qA.size() >= 1);
      aWEn = wEn; aWData = wData; aREn = rEn;
      #1;
      checkOutput("aMemREn", aMemREn, rAcc);
      checkOutput("aMemWEn", aMemWEn, wAcc ? 32'hF : 32'h0);
      if (rAcc) expQA.push_back(qA.pop_front());
      if (wAcc) for (int b = 0; b < 4; b++) qA.push_back(wData[b*8 +: 8]);
      if (wEn && !wAcc) errWA = 1'b1;
      if (rEn && !rAcc) errRA = 1'b1;
      @(posedge clk);
      #1;
      aWEn = 1'b0; aREn = 1'b0;
      lvl = qA.size();
      checkOutput("aLevel", aLevel, lvl);
      checkOutput("aWFull", aWFull, lvl > 1020);
      checkOutput("aREmpty", aREmpty, lvl < 1);
      checkOutput("aRValid", aRValid, rAcc);
      if (rAcc) begin
         lastA = expQA.pop_front();
         haveLastA = 1'b1;
         checkOutput("aRData", aRData, lastA);
      end else if (haveLastA) begin
         checkOutput("aRDataHold", aRData, lastA);
      end
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
      checkOutput("aWErr", aWErr, errWA);
      checkOutput("aRErr", aRErr, errRA);
`endif
   endtask

   // One cycle on instance B: same structure, narrow writes and wide reads
   task automatic applyStimulusB(input logic wEn, input logic [7:0] wData, input logic rEn);
      logic        wAcc, rAcc;
      logic [31:0] word;
      int          lvl;
      wAcc = wEn && !(qB.size() > 15);
      rAcc = rEn && (qB.size() >= 4);
      bWEn = wEn; bWData = wData; bREn = rEn;
      #1;
      checkOutput("bMemREn", bMemREn, rAcc);
      checkOutput("bMemWEn", bMemWEn, wAcc ? (32'h1 << (bWrCount % 4)) : 32'h0);
      if (rAcc) begin
         word = '0;
         for (int b = 0; b < 4; b++) word[b*8 +: 8] = qB.pop_front();
         expQB.push_back(word);
      end
      if (wAcc) begin
         qB.push_back(wData);
         bWrCount++;
      end
      if (wEn && !wAcc) errWB = 1'b1;
      if (rEn && !rAcc) errRB = 1'b1;
      @(posedge clk);
      #1;
      bWEn = 1'b0; bREn = 1'b0;
      lvl = qB.size();
      checkOutput("bLevel", bLevel, lvl);
      checkOutput("bWFull", bWFull, lvl > 15);
      checkOutput("bREmpty", bREmpty, lvl < 4);
      checkOutput("bRValid", bRValid, rAcc);
      if (rAcc) begin
         lastB = expQB.pop_front();
         haveLastB = 1'b1;
         checkOutput("bRData", bRData, lastB);
      end else if (haveLastB) begin
         checkOutput("bRDataHold", bRData, lastB);
      end
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
      checkOutput("bWErr", bWErr, errWB);
      checkOutput("bRErr", bRErr, errRB);
`endif
   endtask

   initial begin
      arst_n = 1'b0;
      aWEn = 1'b0; aREn = 1'b0; aWData = '0;
      bWEn = 1'b0; bREn = 1'b0; bWData = '0;
      clearModels();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstAEmpty", aREmpty, 1);
      checkOutput("rstAFull", aWFull, 0);
      checkOutput("rstALevel", aLevel, 0);
      checkOutput("rstAValid", aRValid, 0);
      checkOutput("rstAMemWEn", aMemWEn, 0);
      checkOutput("rstAMemREn", aMemREn, 0);
      checkOutput("rstBEmpty", bREmpty, 1);
      checkOutput("rstBLevel", bLevel, 0);
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill A with words i+10 until full, then one extra write that must be rejected
      for (int i = 0; i < 256; i++) applyStimulusA(1'b1, 32'(i + 10), 1'b0);
      checkOutput("fillFull", aWFull, 1);
      checkOutput("fillLevel", aLevel, 1024);
      applyStimulusA(1'b1, 32'hDEAD_BEEF, 1'b0);
      checkOutput("overLevel", aLevel, 1024);

      // Drain byte by byte; the scoreboard expects 0x0A,0,0,0,0x0B,...
      for (int i = 0; i < 1024; i++) applyStimulusA(1'b0, '0, 1'b1);
      checkOutput("drainEmpty", aREmpty, 1);
      applyStimulusA(1'b0, '0, 1'b1);

      // Simultaneous write and read at level 8
      applyStimulusA(1'b1, 32'h4433_2211, 1'b0);
      applyStimulusA(1'b1, 32'h8877_6655, 1'b0);
      applyStimulusA(1'b1, 32'hCCBB_AA99, 1'b1);
      checkOutput("simLevel", aLevel, 11);
      for (int i = 0; i < 11; i++) applyStimulusA(1'b0, '0, 1'b1);

      // Three more full fill/drain passes with random data to wrap the pointers
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 256; i++) applyStimulusA(1'b1, $urandom, 1'b0);
         for (int i = 0; i < 1024; i++) applyStimulusA(1'b0, '0, 1'b1);
      end

      // Random mixed traffic
      for (int i = 0; i < 600; i++)
         applyStimulusA(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) != 0));

      // Instance B: three bytes are not enough for a 32-bit read, the fourth is
      applyStimulusB(1'b1, 8'h01, 1'b0);
      applyStimulusB(1'b1, 8'h02, 1'b0);
      applyStimulusB(1'b1, 8'h03, 1'b0);
      checkOutput("bEmpty3", bREmpty, 1);
      applyStimulusB(1'b1, 8'h04, 1'b0);
      checkOutput("bEmpty4", bREmpty, 0);
      applyStimulusB(1'b0, '0, 1'b1);
      checkOutput("bWord", bRData, 32'h0403_0201);
      for (int i = 0; i < 300; i++)
         applyStimulusB(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0));
      for (int i = 0; i < 6; i++) applyStimulusB(1'b0, '0, 1'b1);

      // Reset in the middle of traffic, with a read result on the output
      applyStimulusA(1'b1, 32'h1234_5678, 1'b0);
      applyStimulusA(1'b1, 32'h9ABC_DEF0, 1'b0);
      applyStimulusA(1'b0, '0, 1'b1);
      arst_n = 1'b0;
      #1;
      checkOutput("midRstLevel", aLevel, 0);
      checkOutput("midRstValid", aRValid, 0);
      checkOutput("midRstEmpty", aREmpty, 1);
      checkOutput("midRstBLevel", bLevel, 0);
      @(negedge clk);
      arst_n = 1'b1;
      clearModels();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) applyStimulusA(1'b1, $urandom, 1'b0);
      for (int i = 0; i < 17; i++) applyStimulusA(1'b0, '0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
